// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the fp_mult arbiter slice: operand width,
// rounding-mode encoding, status flag positions and the round-robin step helper.
package fp_mult_pkg;

  localparam int FP_W  = 32;
  localparam int ST_W  = 8;
  localparam int RND_W = 3;

  typedef enum logic [2:0] {
    IEEE_near = 3'b000,
    IEEE_zero = 3'b001,
    IEEE_pinf = 3'b010,
    IEEE_ninf = 3'b011,
    away_zero = 3'b100
  } round_mode_t;

  localparam int ST_INVALID = 0;
  localparam int ST_INF     = 1;
  localparam int ST_ZERO    = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Requester-side bus of the shared multiplier: request handshake, packed
// operands, response return and per-requester outstanding flags.
interface fp_mult_arbiter_if
  import fp_mult_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*FP_W-1:0]  req_a;
  logic [NREQ*FP_W-1:0]  req_b;
  logic [NREQ*RND_W-1:0] req_rnd;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [FP_W-1:0]       rsp_z;
  logic [ST_W-1:0]       rsp_status;
  logic [NREQ-1:0]       busy;

  modport master (
    output req_valid, req_a, req_b, req_rnd,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_status, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_rnd,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_status, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after i_ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_elig,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_gnt_idx,
  output logic         o_gnt_any
);

  int   w_idx;
  logic w_take;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    w_idx     = 0;
    w_take    = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx  = (int'(i_ptr) + k) % N;
      w_take = i_elig[w_idx] & ~o_gnt_any;
      if (w_take) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = W'(w_idx);
        o_gnt_any    = 1'b1;
      end else begin
        o_gnt_any = o_gnt_any;
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined fp_mult between NREQ requesters: round-robin issue,
// LAT-deep owner tag pipe, one outstanding operation per requester.
module fp_mult_arbiter
  import fp_mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  fp_mult_arbiter_if.slave  bus,
  output logic [FP_W-1:0]   o_mul_a,
  output logic [FP_W-1:0]   o_mul_b,
  output logic [RND_W-1:0]  o_mul_rnd,
  input  logic [FP_W-1:0]   i_mul_z,
  input  logic [ST_W-1:0]   i_mul_status
);

  logic [IDW-1:0]  r_rr_ptr;
  logic [NREQ-1:0] r_busy;
  logic [LAT-1:0]  r_tag_vld;
  logic [IDW-1:0]  r_tag_id [LAT];

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_rsp_hit;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_gnt_any;
  logic            w_rsp_valid;
  logic [IDW-1:0]  w_rsp_id;

  // Reset also masks the tag output so a stale entry never shows during rst.
  assign w_rsp_valid = r_tag_vld[LAT-1] & ~rst;
  assign w_rsp_id    = r_tag_id[LAT-1];

  // A result returning this cycle re-opens its owner for a back-to-back issue.
  always_comb begin
    w_rsp_hit = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rsp_hit[i] = w_rsp_valid & (w_rsp_id == IDW'(i));
    end
    w_elig = bus.req_valid & (~r_busy | w_rsp_hit) & {NREQ{~rst}};
  end

  rr_arbiter #(
    .N (NREQ),
    .W (IDW)
  ) u_rr (
    .i_elig    (w_elig),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  always_comb begin
    o_mul_a   = '0;
    o_mul_b   = '0;
    o_mul_rnd = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_mul_a   = o_mul_a   | (bus.req_a[FP_W*i +: FP_W]    & {FP_W{w_gnt[i]}});
      o_mul_b   = o_mul_b   | (bus.req_b[FP_W*i +: FP_W]    & {FP_W{w_gnt[i]}});
      o_mul_rnd = o_mul_rnd | (bus.req_rnd[RND_W*i +: RND_W] & {RND_W{w_gnt[i]}});
    end
  end

  // Pointer, outstanding flags and tag valids; a new issue beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_busy    <= '0;
      r_tag_vld <= '0;
    end else begin
      if (w_gnt_any) begin
        r_rr_ptr <= IDW'(rr_next(int'(w_gnt_idx), NREQ));
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
      r_busy       <= (r_busy & ~w_rsp_hit) | w_gnt;
      r_tag_vld[0] <= w_gnt_any;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
      end
    end
  end

  // Owner ids are qualified by the valids, so they carry no reset.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_gnt_idx;
    for (int i = 1; i < LAT; i++) begin
      r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign bus.req_ready  = w_gnt;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_id     = w_rsp_id;
  assign bus.rsp_z      = w_rsp_valid ? i_mul_z : '0;
  assign bus.rsp_status = w_rsp_valid ? i_mul_status : '0;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: LAT=1 and LAT=3 instances share one stimulus
// stream and are checked against a due-time model of owners and results.
module tb_fp_mult_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   tb_valid;
  logic [127:0] tb_a;
  logic [127:0] tb_b;
  logic [11:0]  tb_rnd;

  logic [31:0] m_a [2];
  logic [31:0] m_b [2];
  logic [2:0]  m_rnd [2];
  logic [31:0] z_in [2];
  logic [7:0]  s_in [2];

  logic [3:0]  ob_ready [2];
  logic        ob_rvld [2];
  logic [1:0]  ob_rid [2];
  logic [31:0] ob_rz [2];
  logic [7:0]  ob_rst [2];
  logic [3:0]  ob_busy [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit armed   = 1'b0;

  int          lat_m [2];
  int          ptr_m [2];
  int          due_m [2][4];
  logic [31:0] zexp_m [2][4];
  logic [7:0]  sexp_m [2][4];
  int          g_m [2];
  int          hit_m [2];

  fp_mult_arbiter_if #(.NREQ(4)) bus1 ();
  fp_mult_arbiter_if #(.NREQ(4)) bus3 ();

  fp_mult_arbiter #(.NREQ(4), .LAT(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave),
    .o_mul_a (m_a[0]), .o_mul_b (m_b[0]), .o_mul_rnd (m_rnd[0]),
    .i_mul_z (z_in[0]), .i_mul_status (s_in[0])
  );

  fp_mult_arbiter #(.NREQ(4), .LAT(3)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3.slave),
    .o_mul_a (m_a[1]), .o_mul_b (m_b[1]), .o_mul_rnd (m_rnd[1]),
    .i_mul_z (z_in[1]), .i_mul_status (s_in[1])
  );

  assign bus1.req_valid = tb_valid;
  assign bus1.req_a     = tb_a;
  assign bus1.req_b     = tb_b;
  assign bus1.req_rnd   = tb_rnd;
  assign bus3.req_valid = tb_valid;
  assign bus3.req_a     = tb_a;
  assign bus3.req_b     = tb_b;
  assign bus3.req_rnd   = tb_rnd;

  assign ob_ready[0] = bus1.req_ready;  assign ob_ready[1] = bus3.req_ready;
  assign ob_rvld[0]  = bus1.rsp_valid;  assign ob_rvld[1]  = bus3.rsp_valid;
  assign ob_rid[0]   = bus1.rsp_id;     assign ob_rid[1]   = bus3.rsp_id;
  assign ob_rz[0]    = bus1.rsp_z;      assign ob_rz[1]    = bus3.rsp_z;
  assign ob_rst[0]   = bus1.rsp_status; assign ob_rst[1]   = bus3.rsp_status;
  assign ob_busy[0]  = bus1.busy;       assign ob_busy[1]  = bus3.busy;

  // Stand-in for fp_mult: exact for the 2.0*3.0 vector, a mixing hash otherwise.
  function automatic logic [31:0] mul_stub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) begin
      return 32'h40C0_0000;
    end else begin
      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
    end
  endfunction

  logic [31:0] p1_z;
  logic [7:0]  p1_s;
  logic [31:0] p3_z [3];
  logic [7:0]  p3_s [3];

  always @(posedge clk) begin
    p1_z    <= mul_stub(m_a[0], m_b[0]);
    p1_s    <= {m_b[0][4:0], m_rnd[0]};
    p3_z[0] <= mul_stub(m_a[1], m_b[1]);
    p3_s[0] <= {m_b[1][4:0], m_rnd[1]};
    p3_z[1] <= p3_z[0];
    p3_s[1] <= p3_s[0];
    p3_z[2] <= p3_z[1];
    p3_s[2] <= p3_s[1];
  end

  assign z_in[0] = p1_z;
  assign s_in[0] = p1_s;
  assign z_in[1] = p3_z[2];
  assign s_in[1] = p3_s[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    tb_a[32*i +: 32]  = a;
    tb_b[32*i +: 32]  = b;
    tb_rnd[3*i +: 3]  = r;
  endtask

  // Settle after the input change, predict this cycle, compare both instances.
  task automatic eval();
    logic [3:0]  e_ready;
    logic [3:0]  e_busy;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [2:0]  e_r;
    int          idx;
    string       pre;
    #1;
    for (int d = 0; d < 2; d++) begin
      pre = $sformatf("L%0d_", lat_m[d]);
      hit_m[d] = -1;
      for (int i = 0; i < 4; i++) begin
        if (due_m[d][i] == cyc) hit_m[d] = i;
      end
      g_m[d] = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (ptr_m[d] + k) % 4;
        if (!rst && g_m[d] < 0 && tb_valid[idx] &&
            (due_m[d][idx] < 0 || due_m[d][idx] == cyc)) g_m[d] = idx;
      end
      e_ready = 4'b0000;
      e_a = 32'h0; e_b = 32'h0; e_r = 3'b000;
      if (g_m[d] >= 0) begin
        e_ready = 4'b0001 << g_m[d];
        e_a = tb_a[32*g_m[d] +: 32];
        e_b = tb_b[32*g_m[d] +: 32];
        e_r = tb_rnd[3*g_m[d] +: 3];
      end
      check_eq({pre, "ready"}, 32'(ob_ready[d]), 32'(e_ready));
      check_eq({pre, "mul_a"}, m_a[d], e_a);
      check_eq({pre, "mul_b"}, m_b[d], e_b);
      check_eq({pre, "mul_rnd"}, 32'(m_rnd[d]), 32'(e_r));
      if (hit_m[d] >= 0 && !rst) begin
        check_eq({pre, "rsp_valid"}, 32'(ob_rvld[d]), 32'd1);
        check_eq({pre, "rsp_id"}, 32'(ob_rid[d]), 32'(hit_m[d]));
        check_eq({pre, "rsp_z"}, ob_rz[d], zexp_m[d][hit_m[d]]);
        check_eq({pre, "rsp_status"}, 32'(ob_rst[d]), 32'(sexp_m[d][hit_m[d]]));
      end else begin
        check_eq({pre, "rsp_valid"}, 32'(ob_rvld[d]), 32'd0);
        check_eq({pre, "rsp_z"}, ob_rz[d], 32'h0);
        check_eq({pre, "rsp_status"}, 32'(ob_rst[d]), 32'h0);
      end
      if (armed) begin
        e_busy = 4'b0000;
        for (int i = 0; i < 4; i++) e_busy[i] = (due_m[d][i] >= 0);
        check_eq({pre, "busy"}, 32'(ob_busy[d]), 32'(e_busy));
      end
    end
  endtask

  // Advance the model across the clock edge, then wait for the next negedge.
  task automatic tick();
    int g;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ptr_m[d] = 0;
        for (int i = 0; i < 4; i++) due_m[d][i] = -1;
      end else begin
        if (hit_m[d] >= 0) due_m[d][hit_m[d]] = -1;
        g = g_m[d];
        if (g >= 0) begin
          due_m[d][g]  = cyc + lat_m[d];
          zexp_m[d][g] = mul_stub(tb_a[32*g +: 32], tb_b[32*g +: 32]);
          sexp_m[d][g] = {tb_b[32*g +: 5], tb_rnd[3*g +: 3]};
          ptr_m[d]     = (g + 1) % 4;
        end
      end
    end
    if (rst) armed = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    tb_valid = 4'b0000;
    for (int k = 0; k < n; k++) begin
      eval();
      tick();
    end
  endtask

  initial begin
    int seq [6];
    bit pat [7];
    lat_m[0] = 1;
    lat_m[1] = 3;
    for (int d = 0; d < 2; d++) begin
      ptr_m[d] = 0;
      for (int i = 0; i < 4; i++) begin
        due_m[d][i] = -1;
        zexp_m[d][i] = 32'h0;
        sexp_m[d][i] = 8'h0;
      end
    end
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0; seq[5] = 1;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b0; pat[5] = 1'b0; pat[6] = 1'b1;

    rst = 1'b1;
    tb_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 32'h3F80_0000 + 32'(i), 32'h4000_0010 + 32'(i), 3'(i));
    @(negedge clk);

    // Reset with all requesters asserting.
    for (int k = 0; k < 2; k++) begin
      eval();
      check_eq("rst_ready_L1", 32'(ob_ready[0]), 32'h0);
      check_eq("rst_rvld_L1", 32'(ob_rvld[0]), 32'h0);
      tick();
    end

    // Fairness after release: 0,1,2,3,0,1 on the LAT=1 instance.
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      eval();
      check_eq("fair_seq", 32'(ob_ready[0]), 32'(4'b0001 << seq[k]));
      tick();
    end
    idle(4);

    // Single 2.0*3.0 operation from requester 0.
    tb_valid = 4'b0001;
    set_req(0, 32'h4000_0000, 32'h4040_0000, 3'b000);
    eval();
    check_eq("single_mul_a", m_a[0], 32'h4000_0000);
    check_eq("single_mul_b", m_b[0], 32'h4040_0000);
    tick();
    tb_valid = 4'b0000;
    eval();
    check_eq("single_rvld", 32'(ob_rvld[0]), 32'd1);
    check_eq("single_rid", 32'(ob_rid[0]), 32'd0);
    check_eq("single_rz", ob_rz[0], 32'h40C0_0000);
    tick();
    eval();
    check_eq("single_busy0", 32'(ob_busy[0][0]), 32'd0);
    tick();
    idle(3);

    // Outstanding limit on LAT=3: requester 2 held valid alone.
    tb_valid = 4'b0100;
    for (int k = 0; k < 7; k++) begin
      eval();
      check_eq("outst_ready2", 32'(ob_ready[1][2]), 32'(pat[k]));
      tick();
    end
    idle(4);

    // Reset one cycle after an issue on requester 1 drops the in-flight tag.
    tb_valid = 4'b0010;
    eval();
    tick();
    tb_valid = 4'b0000;
    rst = 1'b1;
    eval();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      eval();
      check_eq("midrst_rvld_L3", 32'(ob_rvld[1]), 32'd0);
      tick();
    end
    eval();
    check_eq("midrst_busy_L3", 32'(ob_busy[1]), 32'h0);
    tick();

    // Rounding mode passthrough from requester 3, then an idle cycle.
    tb_valid = 4'b1000;
    set_req(3, 32'h4120_0000, 32'h3F00_0000, 3'b100);
    eval();
    check_eq("rnd_pass", 32'(m_rnd[0]), 32'(3'b100));
    tick();
    tb_valid = 4'b0000;
    eval();
    check_eq("rnd_idle", 32'(m_rnd[0]), 32'(3'b000));
    check_eq("a_idle", m_a[0], 32'h0);
    tick();

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      tb_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
      rst = ($urandom_range(0, 39) == 0);
      eval();
      tick();
    end
    rst = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one pipelined fp_mult datapath between NREQ independent requesters.
- Round-robin arbitration selects one requester per cycle and drives the chosen a/b/rnd onto the multiplier inputs.
- A tag pipeline of depth LAT tracks the owner of each in-flight operation and routes z/status back with the requester id.
- Each requester may have at most one operation outstanding.

Parameters:
- NREQ, 4, number of requesters (2..16)
- LAT, 1, cycles from operand presentation on mul_a/mul_b to valid mul_z/mul_status (>=1)
- IDW, $clog2(NREQ), requester id width (derived, do not override)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- req_a  in  NREQ*32  operand a, requester i at [32i+31:32i]
- req_b  in  NREQ*32  operand b, same packing
- req_rnd  in  NREQ*3  rounding mode, requester i at [3i+2:3i]
- mul_a  out  32  operand a to fp_mult
- mul_b  out  32  operand b to fp_mult
- mul_rnd  out  3  rounding mode to fp_mult
- mul_z  in  32  fp_mult result
- mul_status  in  8  fp_mult status flags
- rsp_valid  out  1  result valid, one cycle, no backpressure
- rsp_id  out  IDW  owner of the result
- rsp_z  out  32  result
- rsp_status  out  8  status
- busy  out  NREQ  outstanding flag per requester

Behaviour:
- Reset (rst=1 at a clk edge):
  - rr_ptr=0, busy=0, all tag valids=0.
  - While rst=1: req_ready=0, rsp_valid=0, mul_a/mul_b/mul_rnd=0.
- Eligibility: elig[i] = req_valid[i] & (!busy[i] | (rsp_valid & rsp_id==i)). A result for i returning in the same cycle re-opens i.
- Grant (combinational):
  - Pick the first eligible index scanning rr_ptr, rr_ptr+1, ... with modulo NREQ wrap.
  - req_ready is one-hot on that index, or all zero if none are eligible.
- Issue cycle: mul_a/mul_b/mul_rnd carry the granted requester's fields; all zero when no grant.
- Pointer update: on grant to g, rr_ptr <= (g+1) mod NREQ; hold on no grant.
- Tag pipe: LAT-entry shift register of {valid,id}. Entry 0 loads {grant_any, g} each cycle; entry LAT-1 drives rsp_valid/rsp_id.
- Response data: rsp_z/rsp_status = mul_z/mul_status when rsp_valid=1, else 0.
- busy[i]:
  - Set on issue to i.
  - Cleared when rsp_valid & rsp_id==i.
  - Set wins over clear in the same cycle.
- Throughput: one issue per cycle. A single requester can issue once every LAT cycles (re-issue allowed in its response cycle).
- Reset mid-operation: in-flight tags are dropped, no rsp_valid for them, and mul_z is ignored until new issues propagate.
- A requester dropping req_valid without a handshake has no effect on state.
- Operands are not registered here; fp_mult's internal pipeline provides the storage. LAT must match the instantiated multiplier.

Decomposition:
- Package fp_mult_pkg:
  - round_mode_t enum: IEEE_near=000, IEEE_zero=001, IEEE_pinf=010, IEEE_ninf=011, away_zero=100
  - status bit index constants
  - FP_W=32
- Sub-module rr_arbiter (parameter N): inputs elig[N] and ptr; outputs one-hot gnt[N], gnt_idx and gnt_any. Purely combinational.

Test Plan:
- Reset: rst=1 with all req_valid=1 -> req_ready=0000, rsp_valid=0. First cycle after release grants requester 0, then rr_ptr=1.
- Single op (LAT=1): req0 a=0x40000000, b=0x40400000, rnd=000 -> issue cycle mul_a=0x40000000, mul_b=0x40400000. Next cycle rsp_valid=1, rsp_id=0, rsp_z=0x40C00000, busy[0] clears.
- Fairness: all four requesters held valid, LAT=1 -> grant sequence 0,1,2,3,0,1 with one issue every cycle and no requester skipped.
- Outstanding limit (LAT=3): only req2 valid, held -> issue at t, req_ready[2]=0 at t+1 and t+2, re-issue at t+3 coincident with rsp_id=2.
- Mid-flight reset (LAT=3): issue req1, assert rst one cycle later -> no rsp_valid ever appears for it, busy=0000.
- Rounding passthrough: req3 rnd=100, others idle -> mul_rnd=100 in the grant cycle; idle cycles give mul_rnd=000 and mul_a=0.
